lcd_frame_buffer_ctrl: RTL

Parametrised LCD timing generator and single-port SRAM frame-buffer scheduler for the SPI display path. It sits between the SPI slave pixel stream and the external asynchronous SRAM and TFT panel. It generalises the fixed 480×272 controller in four ways: configurable panel timing, a write FIFO, RGB565/RGB888 input formats, and optional double-buffered pages with a tear-free swap at frame end.

---
 rtl/lcd_frame_buffer_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_buffer_ctrl
// Description : TFT panel timing generator and single-port SRAM frame-buffer
//               scheduler. Each pixel clock has four mco slots. Slots 0-1
//               write one queued pixel. Slots 2-3 read the displayed pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_buffer_ctrl #(
    parameter int H_ACTIVE   = 480,
    parameter int H_BACK     = 43,
    parameter int H_TOTAL    = 531,
    parameter int H_SYNC     = 1,
    parameter int V_ACTIVE   = 272,
    parameter int V_BACK     = 12,
    parameter int V_TOTAL    = 288,
    parameter int V_SYNC     = 10,
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int DOUBLE_BUF = 1
) (
    input  logic              mco,
    input  logic              rst,
    input  logic [23:0]       i_pix_data,
    input  logic              i_pix_en,
    input  logic              i_fmt888,
    input  logic              i_frame_start,
    input  logic              i_swap,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [23:0]       o_sram_wdata,
    output logic              o_sram_drive,
    input  logic [23:0]       i_sram_rdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_dclk,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [23:0]       o_rgb,
    output logic              o_disp_page,
    output logic [1:0]        o_err
);

    localparam int c_hw = $clog2(H_TOTAL + 1);
    localparam int c_vw = $clog2(V_TOTAL + 1);
    localparam int c_iw = ADDR_W - 1;
    localparam int c_fw = $clog2(FIFO_DEPTH);

    localparam logic [c_hw-1:0] c_h_last   = c_hw'(H_TOTAL - 1);
    localparam logic [c_hw-1:0] c_h_vis_lo = c_hw'(H_BACK);
    localparam logic [c_hw-1:0] c_h_vis_hi = c_hw'(H_BACK + H_ACTIVE);
    localparam logic [c_hw-1:0] c_h_sync   = c_hw'(H_SYNC);
    localparam logic [c_vw-1:0] c_v_last   = c_vw'(V_TOTAL - 1);
    localparam logic [c_vw-1:0] c_v_vis_lo = c_vw'(V_BACK);
    localparam logic [c_vw-1:0] c_v_vis_hi = c_vw'(V_BACK + V_ACTIVE);
    localparam logic [c_vw-1:0] c_v_sync   = c_vw'(V_SYNC);
    localparam logic [c_iw:0]   c_pix_tot  = (c_iw + 1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [c_fw:0]   c_depth    = (c_fw + 1)'(FIFO_DEPTH);

    // Slot, raster and buffer state
    logic [1:0]      s_q;
    logic [c_hw-1:0] h_q, h_d;
    logic [c_vw-1:0] v_q, v_d;
    logic [c_iw-1:0] ri_q, ri_d;
    logic [c_iw-1:0] wi_q;
    logic            dp_q, dp_d;
    logic            swap_q, swap_d;
    logic            tag_q, tag_d;
    logic [1:0]      err_q;

    // Write FIFO: entry = {frame-start tag, stored pixel}
    logic [24:0]     fifo_q [FIFO_DEPTH];
    logic [c_fw:0]   wr_ptr_q, rd_ptr_q;

    // Write slot registers, loaded when entering slot 0
    logic            wr_valid_q;
    logic [c_iw-1:0] wr_idx_q;
    logic [23:0]     wr_data_q;

    // Panel output registers
    logic            hsync_q, vsync_q, de_q;
    logic [23:0]     rgb_q;

    logic            w_leave3, w_full, w_empty, w_push, w_pop, w_tag;
    logic            w_vis, w_hwrap, w_fwrap, w_overrun, w_wr_act;
    logic            w_dp, w_wp;
    logic [c_fw:0]   w_count;
    logic [23:0]     w_pix;
    logic [24:0]     w_head;
    logic [c_iw-1:0] w_index;

    assign w_leave3 = (s_q == 2'd3);
    assign w_count  = wr_ptr_q - rd_ptr_q;
    assign w_full   = (w_count == c_depth);
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_push   = i_pix_en & ~w_full;
    assign w_pop    = w_leave3 & ~w_empty;
    assign w_tag    = tag_q | i_frame_start;
    assign w_pix    = i_fmt888 ? i_pix_data
                               : {8'h00, i_pix_data[4:0], i_pix_data[10:5], i_pix_data[15:11]};
    assign w_head   = fifo_q[rd_ptr_q[c_fw-1:0]];
    assign w_index  = w_head[24] ? '0 : wi_q;
    assign w_overrun = ({1'b0, w_index} >= c_pix_tot);

    assign w_vis   = (h_q >= c_h_vis_lo) && (h_q < c_h_vis_hi) &&
                     (v_q >= c_v_vis_lo) && (v_q < c_v_vis_hi);
    assign w_hwrap = (h_q == c_h_last);
    assign w_fwrap = w_hwrap && (v_q == c_v_last);

    // Single-page builds pin both display and write page to 0
    generate
        if (DOUBLE_BUF != 0) begin : g_dbuf
            assign w_dp = dp_q;
            assign w_wp = ~dp_q;
        end else begin : g_sbuf
            assign w_dp = 1'b0;
            assign w_wp = 1'b0;
        end
    endgenerate

    // Next-state for raster counters, read index, page swap and tag
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        ri_d   = ri_q;
        dp_d   = dp_q;
        swap_d = swap_q | i_swap;
        tag_d  = w_push ? 1'b0 : w_tag;
        if (w_leave3) begin
            if (w_hwrap) begin
                h_d = '0;
                v_d = (v_q == c_v_last) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            if (w_vis) begin
                ri_d = ri_q + 1'b1;
            end
            if (w_fwrap) begin
                ri_d = '0;
                if (swap_d) begin
                    dp_d   = ~dp_q;
                    swap_d = 1'b0;
                end
            end
        end
    end

    // Control state, FIFO pointers, write slot and panel output registers
    always_ff @(posedge mco) begin
        if (rst) begin
            s_q        <= 2'd0;
            h_q        <= '0;
            v_q        <= '0;
            ri_q       <= '0;
            wi_q       <= '0;
            dp_q       <= 1'b0;
            swap_q     <= 1'b0;
            tag_q      <= 1'b0;
            err_q      <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            s_q    <= s_q + 2'd1;
            h_q    <= h_d;
            v_q    <= v_d;
            ri_q   <= ri_d;
            dp_q   <= dp_d;
            swap_q <= swap_d;
            tag_q  <= tag_d;
            err_q[0] <= err_q[0] | (i_pix_en & w_full);
            err_q[1] <= err_q[1] | (w_pop & w_overrun);
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_leave3) begin
                wr_valid_q <= w_pop & ~w_overrun;
                if (w_pop) begin
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    wr_idx_q  <= w_index;
                    wr_data_q <= w_head[23:0];
                    wi_q      <= w_index + 1'b1;
                end
                hsync_q <= ~(h_q < c_h_sync);
                vsync_q <= ~(v_q < c_v_sync);
                de_q    <= w_vis;
                rgb_q   <= w_vis ? i_sram_rdata : 24'h000000;
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge mco) begin
        if (w_push) begin
            fifo_q[wr_ptr_q[c_fw-1:0]] <= {w_tag, w_pix};
        end
    end

    // SRAM bus: write in slots 0-1, display read in slots 2-3
    assign w_wr_act     = wr_valid_q & ~s_q[1];
    assign o_sram_drive = w_wr_act;
    assign o_sram_we_n  = ~w_wr_act;
    assign o_sram_oe_n  = ~(s_q[1] & w_vis);
    assign o_sram_wdata = w_wr_act ? wr_data_q : 24'h000000;
    assign o_sram_addr  = s_q[1]   ? {w_dp, ri_q}
                        : w_wr_act ? {w_wp, wr_idx_q} : '0;

    assign o_dclk      = s_q[1];
    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_de        = de_q;
    assign o_rgb       = rgb_q;
    assign o_disp_page = w_dp;
    assign o_err       = err_q;

endmodule
`default_nettype wire
